// File: rtl/pulse_monitor.sv
// -----------------------------------------------------------------------------
// pulse_monitor
//
// Watches a pulse train, normally the pulse generator's output. It measures
// the high width of each completed pulse and the low gap between consecutive
// pulses, and counts completed pulses. Every result is held in a register,
// and a one-cycle strobe marks each update.
//
// Parameters
//   SYNC_STAGES : extra input flops on pulse_in (0 = same-clock source)
//   CNT_W       : width of the high/low counters and their capture registers
//   PCNT_W      : width of the pulse counter
//
// Ports
//   clk          in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   pulse_in     in   monitored signal
//   clear        in   synchronous clear (highest priority below reset)
//   high_width   out  high cycles of the last completed pulse
//   low_gap      out  low cycles between the last two pulses
//   pulse_count  out  completed pulses, wraps
//   width_valid  out  one-cycle strobe, high_width updated
//   gap_valid    out  one-cycle strobe, low_gap updated
//   overflow     out  sticky, a counter saturated
//   armed        out  high while no measurement is in progress
// -----------------------------------------------------------------------------
module pulse_monitor #(
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned PCNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pulse_in,
  input  logic              clear,
  output logic [CNT_W-1:0]  high_width,
  output logic [CNT_W-1:0]  low_gap,
  output logic [PCNT_W-1:0] pulse_count,
  output logic              width_valid,
  output logic              gap_valid,
  output logic              overflow,
  output logic              armed
);

  typedef enum logic [1:0] {ST_ARM, ST_HIGH, ST_LOW} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  // ---------------------------------------------------------------------------
  // Input path. Every flop here resets to 1, so a line that is already high
  // when reset is released gives no rise, and a partial pulse is never
  // measured. These flops keep tracking the input while clear is asserted.
  // ---------------------------------------------------------------------------
  logic w_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_s = pulse_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments, so each flop
    // samples the value its neighbour held before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync <= '1;
      end else begin
        r_sync[0] <= pulse_in;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
          r_sync[i] <= r_sync[i-1];
        end
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];
  end

  logic r_p_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_p_d <= 1'b1;
    else          r_p_d <= w_s;
  end

  logic w_rise;
  logic w_fall;

  assign w_rise = w_s & ~r_p_d;
  assign w_fall = ~w_s & r_p_d;

  // ---------------------------------------------------------------------------
  // Measurement FSM and datapath
  // ---------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_hcnt, w_hcnt_nxt;
  logic [CNT_W-1:0]    r_lcnt, w_lcnt_nxt;
  logic [CNT_W-1:0]    r_high_width, w_high_width_nxt;
  logic [CNT_W-1:0]    r_low_gap, w_low_gap_nxt;
  logic [PCNT_W-1:0]   r_pulse_count, w_pulse_count_nxt;
  logic                r_width_valid, w_width_valid_nxt;
  logic                r_gap_valid, w_gap_valid_nxt;
  logic                r_overflow, w_overflow_nxt;
  logic                r_armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_ARM;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt       = r_state;
    w_hcnt_nxt        = r_hcnt;
    w_lcnt_nxt        = r_lcnt;
    w_high_width_nxt  = r_high_width;
    w_low_gap_nxt     = r_low_gap;
    w_pulse_count_nxt = r_pulse_count;
    w_width_valid_nxt = 1'b0;
    w_gap_valid_nxt   = 1'b0;
    w_overflow_nxt    = r_overflow;

    if (clear) begin
      // An edge in the same cycle as clear is discarded on purpose.
      w_state_nxt       = ST_ARM;
      w_hcnt_nxt        = '0;
      w_lcnt_nxt        = '0;
      w_high_width_nxt  = '0;
      w_low_gap_nxt     = '0;
      w_pulse_count_nxt = '0;
      w_overflow_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        ST_ARM: begin
          // A fall seen here belongs to a pulse that began before arming.
          if (w_rise) begin
            w_hcnt_nxt  = CNT_ONE;
            w_state_nxt = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            w_high_width_nxt  = r_hcnt;
            w_width_valid_nxt = 1'b1;
            w_pulse_count_nxt = r_pulse_count + PCNT_ONE;
            w_lcnt_nxt        = CNT_ONE;
            w_state_nxt       = ST_LOW;
          end else if (w_s) begin
            if (r_hcnt == CNT_MAX) w_overflow_nxt = 1'b1;
            else                   w_hcnt_nxt     = r_hcnt + CNT_ONE;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_low_gap_nxt   = r_lcnt;
            w_gap_valid_nxt = 1'b1;
            w_hcnt_nxt      = CNT_ONE;
            w_state_nxt     = ST_HIGH;
          end else if (!w_s) begin
            if (r_lcnt == CNT_MAX) w_overflow_nxt = 1'b1;
            else                   w_lcnt_nxt     = r_lcnt + CNT_ONE;
          end
        end
        default: w_state_nxt = ST_ARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt        <= '0;
      r_lcnt        <= '0;
      r_high_width  <= '0;
      r_low_gap     <= '0;
      r_pulse_count <= '0;
      r_width_valid <= 1'b0;
      r_gap_valid   <= 1'b0;
      r_overflow    <= 1'b0;
      r_armed       <= 1'b1;
    end else begin
      r_hcnt        <= w_hcnt_nxt;
      r_lcnt        <= w_lcnt_nxt;
      r_high_width  <= w_high_width_nxt;
      r_low_gap     <= w_low_gap_nxt;
      r_pulse_count <= w_pulse_count_nxt;
      r_width_valid <= w_width_valid_nxt;
      r_gap_valid   <= w_gap_valid_nxt;
      r_overflow    <= w_overflow_nxt;
      // armed is taken from the next state, so it lines up with r_state.
      r_armed       <= (w_state_nxt == ST_ARM);
    end
  end

  assign high_width  = r_high_width;
  assign low_gap     = r_low_gap;
  assign pulse_count = r_pulse_count;
  assign width_valid = r_width_valid;
  assign gap_valid   = r_gap_valid;
  assign overflow    = r_overflow;
  assign armed       = r_armed;

endmodule

// File: tb/tb_pulse_monitor.sv
// -----------------------------------------------------------------------------
// tb_pulse_monitor
//
// Instance A: SYNC_STAGES=0, CNT_W=4, PCNT_W=2 (saturation and wrap are easy
// to reach). Instance B: SYNC_STAGES=2, default widths. B only sees the first
// pulse train. Its strobes must match A's values and arrive two cycles later.
// The stimulus pushes hand-computed expected captures, together with the
// cycle in which each one should be seen, into per-instance queues. A monitor
// pops an entry and compares it whenever a strobe appears.
// -----------------------------------------------------------------------------
module tb_pulse_monitor;

  typedef struct {
    int val;  // expected capture value
    int pc;   // expected pulse_count (width strobes only)
    int at;   // edge count at which the strobe must be observed
  } exp_t;

  logic clk;
  logic reset_n;
  logic pin;
  logic pin_b;
  logic clr;
  logic clr_b;
  bit   b_on;

  logic [3:0]  a_hw, a_lg;
  logic [1:0]  a_pc;
  logic        a_wv, a_gv, a_ovf, a_arm;
  logic [31:0] b_hw, b_lg;
  logic [15:0] b_pc;
  logic        b_wv, b_gv, b_ovf, b_arm;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;

  exp_t wq_a[$];
  exp_t gq_a[$];
  exp_t wq_b[$];
  exp_t gq_b[$];

  pulse_monitor #(.SYNC_STAGES(0), .CNT_W(4), .PCNT_W(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .pulse_in(pin), .clear(clr),
    .high_width(a_hw), .low_gap(a_lg), .pulse_count(a_pc),
    .width_valid(a_wv), .gap_valid(a_gv), .overflow(a_ovf), .armed(a_arm)
  );

  pulse_monitor #(.SYNC_STAGES(2), .CNT_W(32), .PCNT_W(16)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .pulse_in(pin_b), .clear(clr_b),
    .high_width(b_hw), .low_gap(b_lg), .pulse_count(b_pc),
    .width_valid(b_wv), .gap_valid(b_gv), .overflow(b_ovf), .armed(b_arm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares on every strobe, sampled on the falling clock edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (a_wv) begin
        check("A width strobe expected", 64'(wq_a.size() != 0), 64'd1);
        if (wq_a.size() != 0) begin
          e = wq_a.pop_front();
          check("A high_width", 64'(a_hw), 64'(e.val));
          check("A pulse_count", 64'(a_pc), 64'(e.pc));
          check("A width strobe cycle", 64'(edge_cnt), 64'(e.at));
        end
      end
      if (a_gv) begin
        check("A gap strobe expected", 64'(gq_a.size() != 0), 64'd1);
        if (gq_a.size() != 0) begin
          e = gq_a.pop_front();
          check("A low_gap", 64'(a_lg), 64'(e.val));
          check("A gap strobe cycle", 64'(edge_cnt), 64'(e.at));
        end
      end
      if (b_wv) begin
        check("B width strobe expected", 64'(wq_b.size() != 0), 64'd1);
        if (wq_b.size() != 0) begin
          e = wq_b.pop_front();
          check("B high_width", 64'(b_hw), 64'(e.val));
          check("B pulse_count", 64'(b_pc), 64'(e.pc));
          check("B width strobe cycle", 64'(edge_cnt), 64'(e.at));
        end
      end
      if (b_gv) begin
        check("B gap strobe expected", 64'(gq_b.size() != 0), 64'd1);
        if (gq_b.size() != 0) begin
          e = gq_b.pop_front();
          check("B low_gap", 64'(b_lg), 64'(e.val));
          check("B gap strobe cycle", 64'(edge_cnt), 64'(e.at));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Called on a falling edge; the value set is sampled by
  // the next rising edge, i.e. edge number edge_cnt+1.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic c);
    pin = v;
    if (b_on) pin_b = v;
    clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold the line high for n cycles; optionally expect a gap capture on the rise.
  task automatic seg_high(input int n, input bit g_exp, input int g_val);
    if (g_exp) begin
      gq_a.push_back('{g_val, 0, edge_cnt + 1});
      if (b_on) gq_b.push_back('{g_val, 0, edge_cnt + 3});
    end
    repeat (n) step(1'b1, 1'b0);
  endtask

  // Hold the line low for n cycles; optionally expect a width capture on the fall.
  task automatic seg_low(input int n, input bit w_exp, input int w_val, input int pc_val);
    if (w_exp) begin
      wq_a.push_back('{w_val, pc_val, edge_cnt + 1});
      if (b_on) wq_b.push_back('{w_val, pc_val, edge_cnt + 3});
    end
    repeat (n) step(1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    pin     = 1'b0;
    pin_b   = 1'b0;
    clr     = 1'b0;
    clr_b   = 1'b0;
    b_on    = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset values.
    check("reset high_width", 64'(a_hw), 64'd0);
    check("reset low_gap", 64'(a_lg), 64'd0);
    check("reset pulse_count", 64'(a_pc), 64'd0);
    check("reset width_valid", 64'(a_wv), 64'd0);
    check("reset gap_valid", 64'(a_gv), 64'd0);
    check("reset overflow", 64'(a_ovf), 64'd0);
    check("reset armed", 64'(a_arm), 64'd1);
    check("reset B armed", 64'(b_arm), 64'd1);

    // 1 + 6: delay 3, width 2, three pulses, on both A and B (B lags by 2).
    seg_low (3, 1'b0, 0, 0);
    seg_high(2, 1'b0, 0);
    seg_low (3, 1'b1, 2, 1);
    seg_high(2, 1'b1, 3);
    seg_low (3, 1'b1, 2, 2);
    seg_high(2, 1'b1, 3);
    seg_low (5, 1'b1, 2, 3);
    check("gen run pulse_count", 64'(a_pc), 64'd3);
    check("gen run overflow", 64'(a_ovf), 64'd0);
    check("gen run armed", 64'(a_arm), 64'd0);
    check("gen run B pulse_count", 64'(b_pc), 64'd3);
    check("gen run B overflow", 64'(b_ovf), 64'd0);
    b_on  = 1'b0;
    pin_b = 1'b0;

    // 2: reset (asynchronous) with the line high; partial pulse ignored.
    pin     = 1'b1;
    reset_n = 1'b0;
    #1;
    check("async reset pulse_count", 64'(a_pc), 64'd0);
    check("async reset armed", 64'(a_arm), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seg_high(5, 1'b0, 0);
    seg_low (3, 1'b0, 0, 0);
    check("partial pulse not counted", 64'(a_pc), 64'd0);
    seg_high(4, 1'b0, 0);
    seg_low (2, 1'b1, 4, 1);
    check("after partial pulse_count", 64'(a_pc), 64'd1);

    // 3: 20-cycle pulse saturates the 4-bit counter at 15.
    seg_high(20, 1'b1, 2);
    seg_low (2, 1'b1, 15, 2);
    check("saturate overflow", 64'(a_ovf), 64'd1);
    step(1'b0, 1'b1);
    check("clear overflow", 64'(a_ovf), 64'd0);
    check("clear high_width", 64'(a_hw), 64'd0);
    check("clear low_gap", 64'(a_lg), 64'd0);
    check("clear pulse_count", 64'(a_pc), 64'd0);
    check("clear armed", 64'(a_arm), 64'd1);

    // 4: clear in the same cycle as a rise; that pulse is discarded.
    step(1'b1, 1'b1);
    seg_high(2, 1'b0, 0);
    check("clear+rise armed", 64'(a_arm), 64'd1);
    seg_low (3, 1'b0, 0, 0);
    check("clear+rise armed after fall", 64'(a_arm), 64'd1);
    check("clear+rise pulse_count", 64'(a_pc), 64'd0);
    seg_high(2, 1'b0, 0);
    check("next rise armed", 64'(a_arm), 64'd0);
    seg_low (1, 1'b1, 2, 1);

    // 5: five 1-cycle pulses, 1-cycle gaps; 2-bit pulse_count wraps.
    step(1'b0, 1'b1);
    seg_high(1, 1'b0, 0);
    seg_low (1, 1'b1, 1, 1);
    seg_high(1, 1'b1, 1);
    seg_low (1, 1'b1, 1, 2);
    seg_high(1, 1'b1, 1);
    seg_low (1, 1'b1, 1, 3);
    seg_high(1, 1'b1, 1);
    seg_low (1, 1'b1, 1, 0);
    seg_high(1, 1'b1, 1);
    seg_low (3, 1'b1, 1, 1);
    check("wrap final pulse_count", 64'(a_pc), 64'd1);

    repeat (4) @(negedge clk);
    check("A width queue drained", 64'(wq_a.size()), 64'd0);
    check("A gap queue drained", 64'(gq_a.size()), 64'd0);
    check("B width queue drained", 64'(wq_b.size()), 64'd0);
    check("B gap queue drained", 64'(gq_b.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_monitor.md
# pulse_monitor

Cycle-accurate measurement block that sits directly downstream of the pulse generator and observes its `pulse_out`. It measures each pulse's high width and the low gap before the next pulse, and counts completed pulses. Results are presented as registered capture values with one-cycle strobes for the CPU-side PIO/readback logic. It lets software confirm that the programmed delay, width and repetition values were actually produced.

## Interface
- `SYNC_STAGES`, default 0: extra input flops on `pulse_in` (0 = same-clock source; 2 = asynchronous source).
- `CNT_W`, default 32: width of the high and low cycle counters and their capture registers.
- `PCNT_W`, default 16: width of the pulse counter.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `pulse_in`  in  1: monitored signal, normally the generator's `pulse_out`.
- `clear`  in  1: synchronous clear; highest priority below reset.
- `high_width`  out  CNT_W: number of cycles `pulse_in` was high in the last completed pulse.
- `low_gap`  out  CNT_W: number of cycles `pulse_in` was low between the last two pulses.
- `pulse_count`  out  PCNT_W: number of completed pulses (falling edges seen in HIGH).
- `width_valid`  out  1: one-cycle strobe; `high_width` was updated this cycle.
- `gap_valid`  out  1: one-cycle strobe; `low_gap` was updated this cycle.
- `overflow`  out  1: sticky flag; a counter saturated.
- `armed`  out  1: high while in ARM (no measurement in progress).

## Operation
- Input path:
  - `SYNC_STAGES` flops, then one edge flop `p_d`.
  - `s` is the synchronized input, or `pulse_in` directly when `SYNC_STAGES` = 0.
  - `rise = s & ~p_d`; `fall = ~s & p_d`.
  - All sync flops and `p_d` reset to 1. A line that is high at reset release therefore produces no rise edge, and partial pulses are never measured.
- States:
  - ARM (reset state).
  - HIGH.
  - LOW.
- ARM:
  - Ignore `fall`.
  - On `rise`: `hcnt` <= 1, go to HIGH.
- HIGH:
  - While `s`=1: `hcnt` <= `hcnt`+1.
  - On `fall`: `high_width` <= `hcnt`; `width_valid` <= 1; `pulse_count` <= `pulse_count`+1 (wraps at 2^PCNT_W); `lcnt` <= 1; go to LOW.
- LOW:
  - While `s`=0: `lcnt` <= `lcnt`+1.
  - On `rise`: `low_gap` <= `lcnt`; `gap_valid` <= 1; `hcnt` <= 1; go to HIGH.
- Counting rule: a count equals the number of clock cycles in which `s` held the level, so a generator width of W yields `high_width` = W, and a generator delay of D yields `low_gap` = D.
- Saturation:
  - `hcnt` and `lcnt` stop at 2^CNT_W−1 and never wrap.
  - An increment attempted at the maximum sets `overflow`. `overflow` clears only on `clear` or reset.
  - A saturated value is captured as 2^CNT_W−1.
- The delay before the first pulse is not measured, because there is no preceding rise.
- `clear`:
  - State goes to ARM.
  - `hcnt`, `lcnt`, `high_width`, `low_gap`, `pulse_count`, `overflow` and both strobes go to 0.
  - `p_d` and the sync flops keep tracking the input.
  - An edge in the same cycle as `clear` is discarded.
  - If `pulse_in` is high during `clear`, measurement starts at the next rise.
- Reset mid-operation: all state is discarded immediately, asynchronously, and the block restarts in ARM.

## Timing
- Reset values: `high_width`=0, `low_gap`=0, `pulse_count`=0, `width_valid`=0, `gap_valid`=0, `overflow`=0, `armed`=1.
- All outputs are registered.
- If `s` first goes low in cycle t, `high_width`, `pulse_count` and `width_valid` update at the edge ending cycle t and are visible in cycle t+1.
- `gap_valid` behaves the same way relative to the first high cycle after a gap.
- The strobes are high for exactly one cycle.
- `SYNC_STAGES` adds a fixed latency of `SYNC_STAGES` cycles and does not change the measured values.
- Minimum measurable pulse and gap: 1 cycle each. Back-to-back 1-cycle pulses alternate `width_valid` and `gap_valid` every cycle.
- `armed` = (state == ARM), registered.

## Test plan
- Generator-driven run with delay=3, width=2, repetition=3 → `width_valid` fires 3 times with `high_width`=2; `gap_valid` fires 2 times with `low_gap`=3; final `pulse_count`=3; `overflow`=0.
- Reset released while `pulse_in`=1, line falls after 5 cycles, then a 4-cycle pulse → the first partial pulse is not captured; `high_width`=4 and `pulse_count`=1.
- `CNT_W`=4, 20-cycle high pulse → `high_width`=15 and `overflow`=1. After `clear`, `overflow`=0 and all captures are 0.
- `clear` asserted in the same cycle as a `rise` → no `width_valid` for that pulse; `armed` stays 1 until the next rise.
- `PCNT_W`=2, five 1-cycle pulses separated by 1-cycle gaps → `pulse_count` goes 1,2,3,0,1; each `high_width` and `low_gap` = 1; the strobes alternate every cycle.
- `SYNC_STAGES`=2, same stimulus as the first scenario → identical captured values, with the strobes delayed by exactly 2 cycles.
